// File: rtl/vec_lane_sequencer_pkg.sv
// vec_seq_pkg: shared widths, sequencer states and lane ALU op codes.
package vec_seq_pkg;
    localparam int LANES = 4;
    localparam int LANE_W = 32;
    localparam int VEC_W = LANES * LANE_W;
    localparam int OP_W = 3;
    localparam int RD_W = 6;
    localparam int IDX_W = $clog2(LANES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} seqState;
    localparam logic [OP_W-1:0] ADD = 3'b000;
    localparam logic [OP_W-1:0] SUB = 3'b001;
    localparam logic [OP_W-1:0] AND = 3'b010;
    localparam logic [OP_W-1:0] OR = 3'b011;
endpackage

// File: rtl/vec_lane_sequencer_if.sv
// vec_lane_sequencer_if: request, shared-ALU and result signals of the lane sequencer.
interface vec_lane_sequencer_if;
    import vec_seq_pkg::*;
    logic req_valid;
    logic req_ready;
    logic [OP_W-1:0] req_op;
    logic [VEC_W-1:0] req_a;
    logic [VEC_W-1:0] req_b;
    logic [LANES-1:0] req_mask;
    logic [RD_W-1:0] req_rd;
    logic flush;
    logic [LANE_W-1:0] alu_a;
    logic [LANE_W-1:0] alu_b;
    logic [OP_W-1:0] alu_op;
    logic [LANE_W-1:0] alu_result;
    logic stall_o;
    logic busy;
    logic [IDX_W-1:0] lane_idx;
    logic res_valid;
    logic [VEC_W-1:0] res_data;
    logic [RD_W-1:0] res_rd;
    modport master (
        output req_valid, req_op, req_a, req_b, req_mask, req_rd, flush, alu_result,
        input req_ready, alu_a, alu_b, alu_op, stall_o, busy, lane_idx, res_valid, res_data, res_rd
    );
    modport slave (
        input req_valid, req_op, req_a, req_b, req_mask, req_rd, flush, alu_result,
        output req_ready, alu_a, alu_b, alu_op, stall_o, busy, lane_idx, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/vec_lane_sequencer_lane_mask_scan.sv
// lane_mask_scan: lowest set mask bit strictly above a signed start index (-1 scans from lane 0).
module lane_mask_scan
    import vec_seq_pkg::*;
(
    input  logic [LANES-1:0] mask,
    input  logic signed [IDX_W:0] from,
    output logic [IDX_W-1:0] nextIdx,
    output logic found
);
    always_comb begin
        nextIdx = '0;
        found = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && i > int'(from)) begin
                nextIdx = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vec_lane_sequencer.sv
// vec_lane_sequencer: runs one vector op lane by lane through a shared scalar ALU,
// stalling the front end until the assembled result is strobed out.
module vec_lane_sequencer
    import vec_seq_pkg::*;
(
    input logic clk,
    input logic rst,
    vec_lane_sequencer_if.slave bus
);
    seqState state, stateNext;
    logic [LANES-1:0][LANE_W-1:0] opA, opB, resLanes;
    logic [OP_W-1:0] opReg;
    logic [LANES-1:0] maskReg;
    logic [RD_W-1:0] rdReg;
    logic [IDX_W-1:0] laneIdx, scanIdx;
    logic accept, running, found;

    assign running = state == RUN;
    assign accept = bus.req_valid && bus.req_ready && !bus.flush;

    // Accept only happens outside RUN, so one scanner serves both first-lane and advance.
    lane_mask_scan scan (
        .mask(running ? maskReg : bus.req_mask),
        .from(running ? {1'b0, laneIdx} : {(IDX_W + 1){1'b1}}),
        .nextIdx(scanIdx),
        .found(found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = IDLE;
        bus.req_ready = rst && (state == IDLE || state == DONE);
        bus.stall_o = running || accept;
        bus.busy = state != IDLE;
        bus.res_valid = state == DONE;
        bus.alu_a = running ? opA[laneIdx] : '0;
        bus.alu_b = running ? opB[laneIdx] : '0;
        bus.alu_op = running ? opReg : '0;
        bus.lane_idx = laneIdx;
        bus.res_data = resLanes;
        bus.res_rd = rdReg;
        stateNext = bus.flush ? IDLE : (accept || running) ? (found ? RUN : DONE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opA <= '0;
            opB <= '0;
            resLanes <= '0;
            opReg <= '0;
            maskReg <= '0;
            rdReg <= '0;
            laneIdx <= '0;
        end else if (accept) begin
            opA <= bus.req_a;
            opB <= bus.req_b;
            resLanes <= bus.req_a;
            opReg <= bus.req_op;
            maskReg <= bus.req_mask;
            rdReg <= bus.req_rd;
            laneIdx <= scanIdx;
        end else if (running && !bus.flush) begin
            resLanes[laneIdx] <= bus.alu_result;
            if (found) laneIdx <= scanIdx;
        end
    end
endmodule
